// File: rtl/buf_readout_seq_if.sv
// RAM read-port and output-stream bundle for buf_readout_seq.
// master = sequencer side, slave = RAM model / stream consumer side.
interface buf_readout_seq_if #(
  parameter int DATAWIDTH = 512,
  parameter int ADDRWIDTH = 10
);
  logic                 ram_en;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [DATAWIDTH-1:0] ram_dout;
  logic [DATAWIDTH-1:0] m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic                 m_tlast;

  modport master (
    output ram_en, ram_addr, m_tdata, m_tvalid, m_tlast,
    input  ram_dout, m_tready
  );

  modport slave (
    input  ram_en, ram_addr, m_tdata, m_tvalid, m_tlast,
    output ram_dout, m_tready
  );
endinterface

// File: rtl/buf_readout_seq.sv
// Read-side sequencer: fetches nwords wide words from base_addr (wrapping) and streams them out.
// Optional macro BUF_RDOUT_STALL_CNT_EN adds the stall_cnt output.
module buf_readout_seq #(
  parameter int DATAWIDTH = 512,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   nwords,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state,
`ifdef BUF_RDOUT_STALL_CNT_EN
  output logic [31:0]          stall_cnt,
`endif
  buf_readout_seq_if.master    bus
);

  // IDLE is encoded as 0 so dbg_state reads 0 out of reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDRWIDTH:0] MAX_WORDS = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0] ONE_W     = {{ADDRWIDTH{1'b0}}, 1'b1};

  state_t               state_q;
  logic [ADDRWIDTH-1:0] base_q;
  logic [ADDRWIDTH:0]   nwords_q;
  logic [ADDRWIDTH:0]   issued_q;
  logic [ADDRWIDTH:0]   beats_q;
  logic                 out_q;
  logic                 done_q;
  logic [DATAWIDTH-1:0] fifo_q [2];
  logic                 wr_q;
  logic                 rd_q;
  logic [1:0]           cnt_q;

  logic                 pop;
  logic                 push;
  logic                 ram_en;
  logic [1:0]           cnt_d;
  logic [ADDRWIDTH:0]   issued_d;
  logic [ADDRWIDTH:0]   nwords_clamped;
  logic                 start_ok;

  // Stream handshake: a beat transfers on any edge where m_tvalid && m_tready;
  // while m_tvalid && !m_tready the head word is held and m_tvalid stays high
  // (only abort or reset may drop it).
  assign bus.m_tvalid = (cnt_q != 2'd0);
  assign bus.m_tdata  = bus.m_tvalid ? fifo_q[rd_q] : '0;
  assign bus.m_tlast  = bus.m_tvalid && (beats_q == (nwords_q - ONE_W));
  assign pop          = bus.m_tvalid && bus.m_tready;
  assign push         = out_q;

  // Issue only while the in-flight word plus buffered words, less this cycle's
  // pop, leave room in the 2-entry skid FIFO for the new return.
  assign ram_en = (state_q == ST_RUN) && (issued_q < nwords_q) &&
                  ((3'(out_q) + 3'(cnt_q)) < (3'd2 + 3'(pop)));
  assign bus.ram_en   = ram_en;
  assign bus.ram_addr = base_q + issued_q[ADDRWIDTH-1:0];

  assign cnt_d          = cnt_q + 2'(push) - 2'(pop);
  assign issued_d       = issued_q + {{ADDRWIDTH{1'b0}}, ram_en};
  assign nwords_clamped = (nwords > MAX_WORDS) ? MAX_WORDS : nwords;
  assign start_ok       = (state_q == ST_IDLE) && start && !abort;

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      nwords_q <= '0;
      issued_q <= '0;
      beats_q  <= '0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (abort) begin
      // Clearing out_q drops any word still returning from the RAM.
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      done_q <= 1'b0;
      out_q  <= ram_en;
      cnt_q  <= cnt_d;
      if (push) wr_q <= ~wr_q;
      if (pop) begin
        rd_q    <= ~rd_q;
        beats_q <= beats_q + ONE_W;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            base_q   <= base_addr;
            nwords_q <= nwords_clamped;
            issued_q <= '0;
            beats_q  <= '0;
            state_q  <= (nwords_clamped == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          issued_q <= issued_d;
          if (issued_d == nwords_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt_d == 2'd0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data storage needs no reset: occupancy and pointers gate what is visible.
  always_ff @(posedge clk) begin
    if (push && !abort) fifo_q[wr_q] <= bus.ram_dout;
  end

`ifdef BUF_RDOUT_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (bus.m_tvalid && !bus.m_tready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_buf_readout_seq.sv
// Scoreboard bench for buf_readout_seq: random RAM contents, expected stream built
// from base/count with wrap, checked by an independent monitor.
module tb_buf_readout_seq;
  localparam int DW    = 512;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   nwords = '0;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;
`ifdef BUF_RDOUT_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  buf_readout_seq_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus_if ();

  buf_readout_seq #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .nwords    (nwords),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
`ifdef BUF_RDOUT_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus_if)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (1-cycle registered read) ----------------
  logic [DW-1:0] ram [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DW / 32; j++)
        ram[i][j*32 +: 32] = $urandom;
  end

  always @(posedge clk) begin
    if (bus_if.ram_en) bus_if.ram_dout <= ram[bus_if.ram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  bit            last_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            tb_base = 0;
  int            tb_issued = 0;
  int            tb_popped = 0;
  int            stall_model = 0;
  int            ready_mode = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int clamp_n(input int n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  // ---------------- consumer ready generator ----------------
  initial begin
    int ph;
    ph = 0;
    bus_if.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus_if.m_tready = 1'b1;
        1:       bus_if.m_tready = (ph % 3 == 0);
        default: bus_if.m_tready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [DW-1:0] prev_data;
    logic          prev_stall;
    logic          prev_abort;
    logic          pop_now;
    int            inflight;
    prev_data  = '0;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
        prev_abort = 1'b0;
      end else begin
        pop_now = bus_if.m_tvalid && bus_if.m_tready;
        if (prev_stall && !prev_abort) begin
          check("stall_hold_valid", bus_if.m_tvalid, 1);
          check("stall_hold_data", bus_if.m_tdata, prev_data);
        end
        if (bus_if.ram_en) begin
          check("ram_addr", bus_if.ram_addr, (tb_base + tb_issued) % DEPTH);
          inflight = tb_issued + 1 - tb_popped - (pop_now ? 1 : 0);
          check("words_in_flight_le2", inflight <= 2, 1);
          tb_issued++;
        end
        if (bus_if.m_tvalid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected", bus_if.m_tdata);
          end else begin
            check("m_tdata", bus_if.m_tdata, exp_q[0]);
            check("m_tlast", bus_if.m_tlast, last_q[0]);
            if (pop_now) begin
              void'(exp_q.pop_front());
              void'(last_q.pop_front());
            end
          end
          if (pop_now) tb_popped++;
          else stall_model++;
        end else begin
          check("tlast_without_valid", bus_if.m_tlast, 0);
        end
        prev_stall = bus_if.m_tvalid && !bus_if.m_tready;
        prev_data  = bus_if.m_tdata;
        prev_abort = abort;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int b, input int n);
    int en;
    en = clamp_n(n);
    @(posedge clk);
    #1;
    for (int k = 0; k < en; k++) begin
      exp_q.push_back(ram[(b + k) % DEPTH]);
      last_q.push_back(k == en - 1);
    end
    tb_base     = b;
    tb_issued   = 0;
    tb_popped   = 0;
    stall_model = 0;
    start       = 1'b1;
    base_addr   = AW'(b);
    nwords      = (AW+1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_readout(input int b, input int n, input int mode,
                             input bit timing, input bit spurious);
    int en;
    int got;
    int first_en;
    int first_v;
    ready_mode = mode;
    en       = clamp_n(n);
    got      = 0;
    first_en = 0;
    first_v  = 0;
    start_run(b, n);
    check("busy_after_start", busy, 1);
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge clk);
      if (spurious && cyc == 3) begin
        start     = 1'b1;
        base_addr = AW'($urandom);
        nwords    = (AW+1)'($urandom_range(1, 50));
      end
      if (spurious && cyc == 4) start = 1'b0;
      if (bus_if.ram_en && first_en == 0) first_en = cyc;
      if (bus_if.m_tvalid && first_v == 0) first_v = cyc;
      if (done) begin
        got = cyc;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", got != 0, 1);
    check("busy_drops_with_done", busy, 0);
    if (timing) begin
      check("done_cycle", got, (en == 0) ? 2 : en + 3);
      if (en > 0) begin
        check("first_ram_en_cycle", first_en, 1);
        check("first_valid_cycle", first_v, 3);
      end
    end
    check("all_beats_delivered", exp_q.size(), 0);
    check("reads_issued", tb_issued, en);
    @(posedge clk);
    #1;
    check("busy_idle_after_done", busy, 0);
    check("done_single_cycle", done, 0);
`ifdef BUF_RDOUT_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_model);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_en"}, bus_if.ram_en, 0);
    check({tag, "_ram_addr"}, bus_if.ram_addr, 0);
    check({tag, "_m_tvalid"}, bus_if.m_tvalid, 0);
    check({tag, "_m_tdata"}, bus_if.m_tdata, 0);
    check({tag, "_m_tlast"}, bus_if.m_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef BUF_RDOUT_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_state_idle", dbg_state, 0);
    @(negedge clk);
    rstn = 1'b1;

    run_readout(5, 4, 0, 1, 0);       // basic
    run_readout(1022, 4, 0, 1, 0);    // address wrap
    run_readout(100, 6, 1, 0, 0);     // 1,0,0 backpressure
    run_readout(7, 0, 0, 1, 0);       // zero count
    run_readout(512, 1500, 0, 1, 0);  // clamp to full buffer, full wrap
    run_readout(300, 1500, 2, 0, 0);  // clamp under random backpressure
    for (int i = 0; i < 6; i++)
      run_readout($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2, 0, 0);

    // abort after two beats of eight
    ready_mode = 0;
    start_run(200, 8);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tb_popped >= 2) break;
    end
    check("abort_reached_beat2", tb_popped >= 2, 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    last_q.delete();
    check("abort_valid_low", bus_if.m_tvalid, 0);
    check("abort_busy_low", busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || bus_if.m_tvalid) saw = 1'b1;
    end
    check("abort_no_done_or_beat", saw, 0);
    run_readout(40, 3, 0, 1, 0);

    // abort and start together: start dropped
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    base_addr = AW'(9);
    nwords = (AW+1)'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start_busy", busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.ram_en || bus_if.m_tvalid || done) saw = 1'b1;
    end
    check("abort_beats_start_idle", saw, 0);

    // asynchronous reset mid-run, then a run with an ignored start
    ready_mode = 2;
    start_run($urandom_range(0, DEPTH - 1), 40);
    repeat (10) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    last_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_readout($urandom_range(0, DEPTH - 1), 10, 1, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/buf_readout_seq.md
Name: buf_readout_seq

Overview:
- Read-side sequencer for the wide-read asymmetric sample buffer; drives its 512-bit read port and streams the words out.
- On start, reads nwords consecutive wide words from base_addr, with address wrap.
- Absorbs the RAM's 1-cycle registered read latency in a 2-entry skid FIFO.
- Presents data as a valid/ready stream with last-beat marking, feeding the host/DMA readout path.

Parameters:
DATAWIDTH, 512, width of RAM read word and output stream data
ADDRWIDTH, 10, RAM read-port address width (buffer depth 2^ADDRWIDTH words)

Ports:
clk  in  1  single clock; RAM read port shares this clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a readout; ignored while busy
abort  in  1  cancel the current readout
base_addr  in  ADDRWIDTH  first word address, sampled on accepted start
nwords  in  ADDRWIDTH+1  word count, sampled on accepted start; values above 2^ADDRWIDTH are clamped to 2^ADDRWIDTH
ram_en  out  1  RAM read enable (enaB)
ram_addr  out  ADDRWIDTH  RAM read address (addrB)
ram_dout  in  DATAWIDTH  RAM read data (doB), valid the cycle after ram_en
m_tdata  out  DATAWIDTH  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  high with the final word
busy  out  1  high from accepted start until done or abort
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN once nwords reads have been issued.
  - DRAIN -> IDLE when the FIFO is empty and no read is outstanding.
  - Any state -> IDLE on abort.
- Accepted start: latches base_addr and the clamped nwords; zeroes issue count and beat count; busy=1 next cycle.
- nwords=0: state goes IDLE->DRAIN directly; no ram_en and no beats; done pulses 2 cycles after start; busy high for 1 cycle.
- Read issue, combinational in RUN:
  - ram_en = (issued < nwords) && (outstanding + occupancy - pop < 2), where pop = m_tvalid && m_tready.
  - ram_addr = (base + issued) mod 2^ADDRWIDTH, wrapping silently from 2^ADDRWIDTH-1 to 0.
- Read return: outstanding is set on ram_en and cleared the next edge. That edge captures ram_dout into the FIFO tail.
- Output: m_tvalid = FIFO not empty; m_tdata = FIFO head.
  - Head stays stable while m_tvalid && !m_tready (standard valid/ready; valid never drops without a handshake, except on abort).
- m_tlast = m_tvalid && (beat count == nwords-1).
- Latency:
  - start sampled at edge 0 -> ram_en high in cycle 1.
  - First m_tvalid in cycle 3.
  - With m_tready held high, one beat per cycle thereafter.
  - Total beats occupy cycles 3..nwords+2.
- done: single-cycle pulse the cycle after the last-beat handshake; busy drops together with done.
- Start while busy: ignored, with no effect on latched values.
- Abort: next cycle state=IDLE, FIFO flushed, m_tvalid=0, busy=0, no done pulse. Any RAM word returning after abort is discarded.
- Abort and start in the same cycle: abort wins; start is dropped.
- Reset mid-operation: immediate return to reset values; no partial stream resumes.

Optional Feature:
- Macro BUF_RDOUT_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt (32 bits) counts cycles with m_tvalid && !m_tready during the current readout.
  - Cleared on accepted start; saturates at 2^32-1; holds after done.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic run: base=5, nwords=4, m_tready=1, RAM word k holds k.
  - ram_addr 5,6,7,8 in cycles 1-4.
  - m_tdata 5,6,7,8 in cycles 3-6; m_tlast in cycle 6.
  - done in cycle 7.
- Wrap: base=1022, nwords=4 -> addresses 1022,1023,0,1 issued; data order matches; one m_tlast.
- Backpressure: nwords=6, m_tready toggling 1,0,0,1,...
  - No word lost or duplicated; m_tdata stable during stalls.
  - ram_en never fires when outstanding + occupancy would exceed 2.
  - With BUF_RDOUT_STALL_CNT_EN defined, stall_cnt equals the counted stall cycles.
- Zero/clamp: nwords=0 -> no beats, done 2 cycles after start; nwords=1500 -> exactly 1024 beats.
- Abort: abort at beat 2 of 8 -> m_tvalid=0 and busy=0 next cycle, no done; a following start with nwords=3 streams 3 clean beats.
- Reset: rstn low mid-run -> all outputs 0 immediately; start ignored during busy of a second run.
